// File: rtl/idct_pkg.sv
// Shared widths, types and the fixed-point inverse-DCT basis table for idct_1d.
// T[n][k] = round(2048 * c(k)/2 * cos((2n+1)k*pi/16)), c(0) = 1/sqrt(2), c(k>0) = 1.
package idct_pkg;

    localparam int COEF_W      = 12;
    localparam int SAMP_W      = 8;
    localparam int CONST_W     = 12;
    localparam int PROD_W      = 24;
    localparam int SUM_W       = 27;
    localparam int ROUND_SHIFT = 11;

    typedef logic signed [COEF_W-1:0]  coef_t;
    typedef logic        [SAMP_W-1:0]  samp_t;
    typedef logic signed [CONST_W-1:0] cos_t;
    typedef logic signed [PROD_W-1:0]  prod_t;
    typedef logic signed [SUM_W-1:0]   sum_t;

    // Rows 4..7 mirror rows 3..0 with the odd-k columns negated.
    localparam cos_t IDCT_T [8][8] = '{
        '{12'sd724,  12'sd1004,  12'sd946,  12'sd851,  12'sd724,  12'sd569,  12'sd392,  12'sd200},
        '{12'sd724,  12'sd851,   12'sd392, -12'sd200, -12'sd724, -12'sd1004, -12'sd946, -12'sd569},
        '{12'sd724,  12'sd569,  -12'sd392, -12'sd1004, -12'sd724, 12'sd200,   12'sd946,  12'sd851},
        '{12'sd724,  12'sd200,  -12'sd946, -12'sd569,  12'sd724,  12'sd851,  -12'sd392, -12'sd1004},
        '{12'sd724, -12'sd200,  -12'sd946,  12'sd569,  12'sd724, -12'sd851,  -12'sd392,  12'sd1004},
        '{12'sd724, -12'sd569,  -12'sd392,  12'sd1004, -12'sd724, -12'sd200,  12'sd946, -12'sd851},
        '{12'sd724, -12'sd851,   12'sd392,  12'sd200, -12'sd724,  12'sd1004, -12'sd946,  12'sd569},
        '{12'sd724, -12'sd1004,  12'sd946, -12'sd851,  12'sd724, -12'sd569,   12'sd392, -12'sd200}
    };

endpackage

// File: rtl/idct_cos_rom.sv
// Combinational basis ROM: returns the 8 constants of output row n, packed with
// column k in bits [k*CONST_W +: CONST_W].
module idct_cos_rom
    import idct_pkg::*;
(
    input  logic [2:0]           row,
    output logic [8*CONST_W-1:0] consts
);

    always_comb begin
        consts = '0;
        for (int k = 0; k < 8; k++) begin
            consts[k*CONST_W +: CONST_W] = IDCT_T[row][k];
        end
    end

endmodule

// File: rtl/idct_1d.sv
// 8-point 1-D inverse DCT: deserializes 8 coefficients, streams 8 clamped samples.
// Optional macro IDCT_LEVEL_SHIFT_EN adds +128 before the clamp.
module idct_1d
    import idct_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [COEF_W-1:0] data_in,
    output logic [SAMP_W-1:0] data_out,
    output logic              valid_out
);

    localparam sum_t ROUND_BIAS = sum_t'(1 << (ROUND_SHIFT - 1));
    localparam sum_t SAMP_MAX   = sum_t'((1 << SAMP_W) - 1);

    logic [2:0]           in_idx;
    logic [2:0]           out_idx;
    logic                 busy;
    logic                 load;
    coef_t                in_bank   [8];
    coef_t                work_bank [8];
    logic [8*CONST_W-1:0] row_consts;

    logic                 iss_valid;
    coef_t                iss_x [8];
    cos_t                 iss_c [8];
    logic                 s1_valid;
    prod_t                prod [8];
    logic                 s2_valid;
    sum_t                 sum_r;

    sum_t                 tree_sum;
    sum_t                 rounded;
    sum_t                 shifted;
    samp_t                clamped;

    assign load = (in_idx == 3'd7);

    idct_cos_rom u_rom (
        .row    (out_idx),
        .consts (row_consts)
    );

    // The work bank is rewritten on the same edge that issues the previous
    // block's last row; that row's operands are latched in iss_x on that edge.
    always_ff @(posedge clk) begin
        if (en) begin
            in_bank[in_idx] <= data_in;
            if (load) begin
                for (int k = 0; k < 7; k++) begin
                    work_bank[k] <= in_bank[k];
                end
                work_bank[7] <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_idx  <= 3'd0;
            out_idx <= 3'd0;
            busy    <= 1'b0;
        end else if (en) begin
            in_idx <= in_idx + 3'd1;
            if (load) begin
                out_idx <= 3'd0;
                busy    <= 1'b1;
            end else if (busy) begin
                out_idx <= out_idx + 3'd1;
                if (out_idx == 3'd7) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < 8; k++) begin
                iss_x[k] <= work_bank[k];
                iss_c[k] <= row_consts[k*CONST_W +: CONST_W];
                prod[k]  <= prod_t'(iss_x[k]) * prod_t'(iss_c[k]);
            end
            sum_r <= tree_sum;
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < 8; k++) begin
            tree_sum = tree_sum + sum_t'(prod[k]);
        end
    end

    // Round half up, optional level shift, then saturate into the sample range.
    always_comb begin
        rounded = (sum_r + ROUND_BIAS) >>> ROUND_SHIFT;
`ifdef IDCT_LEVEL_SHIFT_EN
        shifted = rounded + sum_t'(128);
`else
        shifted = rounded;
`endif
        if (shifted < sum_t'(0)) begin
            clamped = '0;
        end else if (shifted > SAMP_MAX) begin
            clamped = '1;
        end else begin
            clamped = shifted[SAMP_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (en) begin
            iss_valid <= busy;
            s1_valid  <= iss_valid;
            s2_valid  <= s1_valid;
            valid_out <= s2_valid;
            if (s2_valid) begin
                data_out <= clamped;
            end
        end
    end

endmodule

// File: tb/tb_idct_1d.sv
// Scoreboard bench for idct_1d: a real-arithmetic IDCT model predicts each sample
// and the en edge it must appear on; a monitor pops and compares.
module tb_idct_1d;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [11:0] data_in;
    logic [7:0]  data_out;
    logic        valid_out;

    typedef struct {
        int value;
        int edge_idx;
    } exp_t;

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;
    int   tbl [8][8];
    int   blk [8];
    int   cur [8];
    int   saved [3][8];
    int   blk_idx = 0;
    int   drv_edge = 0;
    int   mon_edge = 0;

    always #5 clk = ~clk;

    idct_1d dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    function automatic void buildTable();
        real pi = 3.14159265358979;
        real ck;
        real t;
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 8; k++) begin
                ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                t  = 2048.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * pi / 16.0);
                tbl[n][k] = $rtoi(t + ((t >= 0.0) ? 0.5 : -0.5));
            end
        end
    endfunction

    // Sample n of the block held in blk: exact dot product, rounded to nearest.
    function automatic int refSample(input int n);
        int sum = 0;
        int v;
        for (int k = 0; k < 8; k++) begin
            sum += blk[k] * tbl[n][k];
        end
        v = $rtoi($floor(real'(sum + 1024) / 2048.0));
`ifdef IDCT_LEVEL_SHIFT_EN
        v += 128;
`endif
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic int rndCoef(input int k);
        if (k == 0) return int'($urandom_range(0, 4095)) - 2048;
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int v);
        en      = 1'b1;
        data_in = 12'(v);
        blk[blk_idx] = v;
        drv_edge++;
        if (blk_idx == 7) begin
            for (int n = 0; n < 8; n++) begin
                sb.push_back('{value: refSample(n), edge_idx: drv_edge + 4 + n});
            end
            blk_idx = 0;
        end else begin
            blk_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stall(input int cycles);
        en = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendBlock(input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) stall(int'($urandom_range(1, 3)));
            applyStimulus(cur[i]);
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset valid_out", int'(valid_out), 0);
        checkOutput("reset data_out", int'(data_out), 0);
        sb.delete();
        blk_idx = 0;
        reset   = 1'b0;
    endtask

    // Monitor: on every en edge a valid sample must match the queue head, both in
    // value and in the en edge it lands on; with en low the outputs must hold.
    initial begin
        exp_t e;
        logic en_at;
        logic rst_at;
        int   prev_v = 0;
        int   prev_d = 0;
        forever begin
            @(posedge clk);
            en_at  = en;
            rst_at = reset;
            #2;
            if (!rst_at && en_at) begin
                mon_edge++;
                if (valid_out) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected valid_out", int'(valid_out), 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("sample value", int'(data_out), e.value);
                        checkOutput("sample edge", mon_edge, e.edge_idx);
                    end
                end else if (sb.size() > 0 && sb[0].edge_idx <= mon_edge) begin
                    e = sb.pop_front();
                    checkOutput("missing valid_out", int'(valid_out), 1);
                end
            end else if (!rst_at) begin
                checkOutput("stall valid hold", int'(valid_out), prev_v);
                checkOutput("stall data hold", int'(data_out), prev_d);
            end
            prev_v = int'(valid_out);
            prev_d = int'(data_out);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        data_in = '0;
        buildTable();
        repeat (2) @(posedge clk);
        #1;
        applyReset();

        cur = '{512, 0, 0, 0, 0, 0, 0, 0};
        sendBlock(1'b0);
        cur = '{-64, 0, 0, 0, 0, 0, 0, 0};
        sendBlock(1'b0);
        cur = '{0, 0, 0, 0, 0, 0, 0, 0};
        sendBlock(1'b0);
        cur = '{0, 256, 0, 0, 0, 0, 0, 0};
        sendBlock(1'b0);
        cur = '{2047, 0, 0, 0, 0, 0, 0, 0};
        sendBlock(1'b0);
        cur = '{-2048, 0, 0, 0, 0, 0, 0, 0};
        sendBlock(1'b0);
        stall(3);

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) cur[i] = rndCoef(i);
            saved[b] = cur;
            sendBlock(1'b0);
        end
        for (int b = 0; b < 3; b++) begin
            cur = saved[b];
            sendBlock(1'b1);
        end

        for (int i = 0; i < 8; i++) cur[i] = rndCoef(i);
        sendBlock(1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(rndCoef(i));
        applyReset();
        for (int i = 0; i < 8; i++) cur[i] = rndCoef(i);
        sendBlock(1'b0);

        repeat (11) applyStimulus(0);
        stall(2);
        applyReset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
